// File: rtl/usb_tx_line_if.sv
// Upstream bit stream into the USB line transmitter, plus line pair and status back out.
// The master side is the packet serializer; the slave side is usb_tx_line.
interface usb_tx_line_if;
   logic bit_in;
   logic bit_in_valid;
   logic dp;
   logic dm;
   logic tx_en;
   logic busy;
   logic done;
   logic err;

   modport master (
      output bit_in,
      output bit_in_valid,
      input  dp,
      input  dm,
      input  tx_en,
      input  busy,
      input  done,
      input  err
   );

   modport slave (
      input  bit_in,
      input  bit_in_valid,
      output dp,
      output dm,
      output tx_en,
      output busy,
      output done,
      output err
   );
endinterface

// File: rtl/usb_tx_line.sv
// USB line transmitter: bit stuffing, NRZI encoding and EOP generation.
// A small bit FIFO absorbs the rate expansion from stuffed bits.
module usb_tx_line #(
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   usb_tx_line_if.slave line
);
   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

   typedef enum logic [2:0] {StIdle, StSend, StEop1, StEop2, StEopJ} state_e;

   state_e                state_q, state_d;
   logic [FIFO_DEPTH-1:0] mem_q, mem_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [2:0]            ones_q, ones_d;
   logic                  level_q, level_d;
   logic                  valid_q;
   logic                  pkt_end_q, pkt_end_d;
   logic                  drop_q, drop_d;
   logic                  dp_q, dp_d;
   logic                  dm_q, dm_d;
   logic                  tx_en_q, tx_en_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic fifo_empty, fifo_full, head_bit;
   logic pop, wr_req, wr_ok, overflow, start_viol, underrun;
   logic line_vld, line_bit;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FullCnt);
   assign head_bit   = mem_q[rd_ptr_q];
   // A new run of valid bits before the previous packet has drained is rejected whole.
   assign start_viol = line.bit_in_valid && !valid_q && pkt_end_q && (state_q != StIdle);

   always_comb begin
      state_d  = state_q;
      ones_d   = ones_q;
      level_d  = level_q;
      pop      = 1'b0;
      line_vld = 1'b0;
      line_bit = 1'b0;
      underrun = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop      = 1'b1;
               line_vld = 1'b1;
               line_bit = head_bit;
               ones_d   = {2'b00, head_bit};
               state_d  = StSend;
            end
         end
         StSend: begin
            // Stuffing outranks both the next FIFO bit and the EOP transition.
            if (ones_q == 3'd6) begin
               line_vld = 1'b1;
               line_bit = 1'b0;
               ones_d   = 3'd0;
            end else if (!fifo_empty) begin
               pop      = 1'b1;
               line_vld = 1'b1;
               line_bit = head_bit;
               ones_d   = head_bit ? ones_q + 3'd1 : 3'd0;
            end else begin
               underrun = !pkt_end_q;
               state_d  = StEop1;
            end
         end
         StEop1: state_d = StEop2;
         StEop2: state_d = StEopJ;
         StEopJ: begin
            state_d = StIdle;
            level_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      if (line_vld && !line_bit) begin
         level_d = ~level_q;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = line.bit_in_valid && (drop_q || start_viol);
      wr_req   = line.bit_in_valid && !drop_d;
      wr_ok    = wr_req && (!fifo_full || pop);
      overflow = wr_req && !wr_ok;
      if (wr_ok) begin
         mem_d[wr_ptr_q] = line.bit_in;
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({wr_ok, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      pkt_end_d = pkt_end_q;
      if (valid_q && !line.bit_in_valid && !drop_q) begin
         pkt_end_d = 1'b1;
      end
      if (state_d == StIdle && state_q != StIdle) begin
         pkt_end_d = 1'b0;
      end
   end

   // Line outputs are registered, so they follow the state being entered.
   always_comb begin
      dp_d = 1'b1;
      dm_d = 1'b0;
      unique case (state_d)
         StSend: begin
            dp_d = level_d;
            dm_d = ~level_d;
         end
         StEop1, StEop2: begin
            dp_d = 1'b0;
            dm_d = 1'b0;
         end
         default: begin
            dp_d = 1'b1;
            dm_d = 1'b0;
         end
      endcase
      tx_en_d = (state_d != StIdle);
      done_d  = (state_d == StEopJ);
      err_d   = overflow || start_viol || underrun;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ones_q    <= 3'd0;
         level_q   <= 1'b1;
         valid_q   <= 1'b0;
         pkt_end_q <= 1'b0;
         drop_q    <= 1'b0;
         dp_q      <= 1'b1;
         dm_q      <= 1'b0;
         tx_en_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ones_q    <= ones_d;
         level_q   <= level_d;
         valid_q   <= line.bit_in_valid;
         pkt_end_q <= pkt_end_d;
         drop_q    <= drop_d;
         dp_q      <= dp_d;
         dm_q      <= dm_d;
         tx_en_q   <= tx_en_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
      mem_q <= mem_d;
   end

   assign line.dp    = dp_q;
   assign line.dm    = dm_q;
   assign line.tx_en = tx_en_q;
   assign line.done  = done_q;
   assign line.err   = err_q;
   assign line.busy  = (state_q != StIdle) || !fifo_empty;
endmodule
